// File: rtl/load_hazard_scoreboard_if.sv
// load_hazard_scoreboard_if
// Bundles the ID-stage operand/destination info, the pipeline control inputs
// and the scoreboard's stall/perf outputs between ctrl and the scoreboard.
//   master : pipeline control side (drives ID info, ext_stall, flush)
//   slave  : load_hazard_scoreboard (drives stall_id, hazard_src, counters)
interface load_hazard_scoreboard_if #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
);
    localparam int PCW = $clog2(LOAD_LAT + 1);

    logic                        id_valid;
    logic [NUM_SRC*REG_AW-1:0]   id_src_addr;
    logic [NUM_SRC-1:0]          id_src_used;
    logic                        id_is_load;
    logic                        id_dest_we;
    logic [REG_AW-1:0]           id_dest_addr;
    logic                        ext_stall;
    logic                        flush;
    logic                        stall_id;
    logic [NUM_SRC-1:0]          hazard_src;
    logic [PCW-1:0]              pending_cnt;
    logic [CNT_W-1:0]            stall_cycles;

    modport master (
        output id_valid, id_src_addr, id_src_used, id_is_load, id_dest_we,
               id_dest_addr, ext_stall, flush,
        input  stall_id, hazard_src, pending_cnt, stall_cycles
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_is_load, id_dest_we,
               id_dest_addr, ext_stall, flush,
        output stall_id, hazard_src, pending_cnt, stall_cycles
    );
endinterface

// File: rtl/load_hazard_scoreboard.sv
// load_hazard_scoreboard
// Tracks loads for LOAD_LAT cycles after EX and stalls the ID instruction when
// any of its used source operands names one of those in-flight load targets.
// Also keeps a saturating count of hazard-stall cycles.
//   clk  : pipeline clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : slave side of load_hazard_scoreboard_if (ID info in, stall out)

// Per-source comparator: one instance per ID source operand.
module load_hazard_scoreboard_src_match #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                            id_valid_i,
    input  logic                            used_i,
    input  logic [REG_AW-1:0]               src_i,
    input  logic [LOAD_LAT-1:0]             vld_i,
    input  logic [LOAD_LAT-1:0][REG_AW-1:0] addr_i,
    output logic                            hit_o
);
    always_comb begin
        hit_o = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++)
            if (vld_i[k] && (addr_i[k] == src_i)) hit_o = 1'b1;
        // $0 is hardwired, so it never creates a dependency
        if (!id_valid_i || !used_i || (src_i == '0)) hit_o = 1'b0;
    end
endmodule

module load_hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input logic                  clk,
    input logic                  rst,
    load_hazard_scoreboard_if.slave bus
);
    localparam int PCW = $clog2(LOAD_LAT + 1);

    // Tracker: entry 0 = load in EX, entry k = load k cycles past EX
    logic [LOAD_LAT-1:0]             vld_q, vld_d;
    logic [LOAD_LAT-1:0][REG_AW-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_SRC-1:0]              hit;
    logic                            stall;
    logic                            new_vld;
    logic [PCW-1:0]                  pend;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        load_hazard_scoreboard_src_match #(
            .REG_AW   (REG_AW),
            .LOAD_LAT (LOAD_LAT)
        ) u_match (
            .id_valid_i (bus.id_valid),
            .used_i     (bus.id_src_used[i]),
            .src_i      (bus.id_src_addr[i*REG_AW +: REG_AW]),
            .vld_i      (vld_q),
            .addr_i     (addr_q),
            .hit_o      (hit[i])
        );
    end

    assign stall   = |hit;
    // Loads writing $0 or not writing at all can't cause a hazard; keep them out
    assign new_vld = bus.id_valid & bus.id_is_load & bus.id_dest_we &
                     (bus.id_dest_addr != '0);

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        if (bus.flush) begin
            vld_d = '0;
        end else if (!bus.ext_stall) begin
            for (int k = LOAD_LAT - 1; k > 0; k--) begin
                vld_d[k]  = vld_q[k-1];
                addr_d[k] = addr_q[k-1];
            end
            // While stalling, the ID instruction stays put and EX gets a bubble
            vld_d[0]  = new_vld & ~stall;
            addr_d[0] = bus.id_dest_addr;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !bus.ext_stall && !bus.flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        pend = '0;
        for (int k = 0; k < LOAD_LAT; k++) pend = pend + PCW'(vld_q[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.stall_id     = stall;
    assign bus.hazard_src   = hit;
    assign bus.pending_cnt  = pend;
    assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_load_hazard_scoreboard.sv
module tb_load_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [9:0] src_addr = '0;
    logic [1:0] used = '0;
    logic       is_load = 1'b0;
    logic       we = 1'b0;
    logic [4:0] dest = '0;
    logic       ext_stall = 1'b0;
    logic       flush = 1'b0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         sel = 1;
    logic       stall_sel;

    always #5 clk = ~clk;

    load_hazard_scoreboard_if #(.LOAD_LAT(1))             if1 ();
    load_hazard_scoreboard_if #(.LOAD_LAT(2))             if2 ();
    load_hazard_scoreboard_if #(.LOAD_LAT(3))             if3 ();
    load_hazard_scoreboard_if #(.LOAD_LAT(1), .CNT_W(4))  if4 ();

    assign if1.id_valid = id_valid;  assign if1.id_src_addr = src_addr;
    assign if1.id_src_used = used;   assign if1.id_is_load = is_load;
    assign if1.id_dest_we = we;      assign if1.id_dest_addr = dest;
    assign if1.ext_stall = ext_stall; assign if1.flush = flush;
    assign if2.id_valid = id_valid;  assign if2.id_src_addr = src_addr;
    assign if2.id_src_used = used;   assign if2.id_is_load = is_load;
    assign if2.id_dest_we = we;      assign if2.id_dest_addr = dest;
    assign if2.ext_stall = ext_stall; assign if2.flush = flush;
    assign if3.id_valid = id_valid;  assign if3.id_src_addr = src_addr;
    assign if3.id_src_used = used;   assign if3.id_is_load = is_load;
    assign if3.id_dest_we = we;      assign if3.id_dest_addr = dest;
    assign if3.ext_stall = ext_stall; assign if3.flush = flush;
    assign if4.id_valid = id_valid;  assign if4.id_src_addr = src_addr;
    assign if4.id_src_used = used;   assign if4.id_is_load = is_load;
    assign if4.id_dest_we = we;      assign if4.id_dest_addr = dest;
    assign if4.ext_stall = ext_stall; assign if4.flush = flush;

    load_hazard_scoreboard #(.LOAD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    load_hazard_scoreboard #(.LOAD_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    load_hazard_scoreboard #(.LOAD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    load_hazard_scoreboard #(.LOAD_LAT(1), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    assign stall_sel = (sel == 1) ? if1.stall_id :
                       (sel == 2) ? if2.stall_id :
                       (sel == 3) ? if3.stall_id : if4.stall_id;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] u, input logic ld, input logic w,
                         input logic [4:0] d);
        id_valid = v; src_addr = {s1, s0}; used = u; is_load = ld; we = w; dest = d;
        #1;
    endtask

    task automatic nop();              drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0); endtask
    task automatic load(input logic [4:0] d); drive(1'b1, 5'd0, 5'd0, 2'b01, 1'b1, 1'b1, d); endtask
    task automatic use0(input logic [4:0] r); drive(1'b1, r, 5'd0, 2'b01, 1'b0, 1'b1, 5'd3); endtask
    task automatic use1(input logic [4:0] r); drive(1'b1, 5'd0, r, 2'b10, 1'b0, 1'b1, 5'd3); endtask
    task automatic filler();           drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd3); endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
        nop();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts consecutive stall cycles of the selected DUT with ID held
    task automatic count_stall(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!stall_sel) break;
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        // reset state
        do_reset();
        chk("rst_stall1", 32'(if1.stall_id), 32'd0);
        chk("rst_haz1", 32'(if1.hazard_src), 32'd0);
        chk("rst_pend3", 32'(if3.pending_cnt), 32'd0);
        chk("rst_cyc1", 32'(if1.stall_cycles), 32'd0);

        // lw $1,0($0); ori $3,$1,1 with LOAD_LAT=1
        sel = 1;
        load(5'd1);
        chk("t1_load_nostall", 32'(if1.stall_id), 32'd0);
        tick();
        use0(5'd1);
        chk("t1_stall", 32'(if1.stall_id), 32'd1);
        chk("t1_haz", 32'(if1.hazard_src), 32'b01);
        chk("t1_pend", 32'(if1.pending_cnt), 32'd1);
        tick();
        chk("t1_release", 32'(if1.stall_id), 32'd0);
        chk("t1_pend_after", 32'(if1.pending_cnt), 32'd0);
        chk("t1_cycles", 32'(if1.stall_cycles), 32'd1);

        // LOAD_LAT=3, consumer of $5 at distance 1..4
        sel = 3;
        for (int d = 1; d <= 4; d++) begin
            do_reset();
            load(5'd5);
            tick();
            for (int f = 1; f < d; f++) begin
                filler();
                tick();
            end
            use1(5'd5);
            count_stall(n);
            chk($sformatf("t2_dist%0d_stalls", d), 32'(n), 32'(4 - d));
            chk($sformatf("t2_dist%0d_cycles", d), 32'(if3.stall_cycles), 32'(4 - d));
            tick();
            nop();
        end

        // loads to $0 and loads that don't write never enter the tracker
        sel = 1;
        do_reset();
        load(5'd0);
        tick();
        chk("t3_r0_pend", 32'(if1.pending_cnt), 32'd0);
        use0(5'd0);
        chk("t3_r0_stall", 32'(if1.stall_id), 32'd0);
        drive(1'b1, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 5'd2);
        tick();
        chk("t3_nowe_pend", 32'(if1.pending_cnt), 32'd0);
        use0(5'd2);
        chk("t3_nowe_stall", 32'(if1.stall_id), 32'd0);

        // both sources on the same load
        do_reset();
        load(5'd7);
        tick();
        drive(1'b1, 5'd7, 5'd7, 2'b11, 1'b0, 1'b1, 5'd8);
        chk("t4_haz11", 32'(if1.hazard_src), 32'b11);
        tick();
        chk("t4_release", 32'(if1.stall_id), 32'd0);
        chk("t4_cycles", 32'(if1.stall_cycles), 32'd1);

        // same, with ext_stall for two cycles during the stall
        do_reset();
        load(5'd7);
        tick();
        drive(1'b1, 5'd7, 5'd7, 2'b11, 1'b0, 1'b1, 5'd8);
        ext_stall = 1'b1;
        #1;
        chk("t4e_stall_a", 32'(if1.stall_id), 32'd1);
        tick();
        chk("t4e_stall_b", 32'(if1.stall_id), 32'd1);
        chk("t4e_cycles_held", 32'(if1.stall_cycles), 32'd0);
        tick();
        ext_stall = 1'b0;
        #1;
        chk("t4e_stall_c", 32'(if1.stall_id), 32'd1);
        tick();
        chk("t4e_release", 32'(if1.stall_id), 32'd0);
        chk("t4e_cycles", 32'(if1.stall_cycles), 32'd1);

        // LOAD_LAT=2: flush mid-stall
        sel = 2;
        do_reset();
        load(5'd4);
        tick();
        chk("t5_pend1", 32'(if2.pending_cnt), 32'd1);
        use0(5'd4);
        chk("t5_stall", 32'(if2.stall_id), 32'd1);
        flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        #1;
        chk("t5f_pend", 32'(if2.pending_cnt), 32'd0);
        chk("t5f_stall", 32'(if2.stall_id), 32'd0);
        chk("t5f_cycles", 32'(if2.stall_cycles), 32'd0);

        // LOAD_LAT=2: reset mid-stall
        do_reset();
        load(5'd4);
        tick();
        use0(5'd4);
        tick();
        chk("t5r_stall2", 32'(if2.stall_id), 32'd1);
        chk("t5r_cycles1", 32'(if2.stall_cycles), 32'd1);
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5r_pend", 32'(if2.pending_cnt), 32'd0);
        chk("t5r_stall", 32'(if2.stall_id), 32'd0);
        chk("t5r_cycles", 32'(if2.stall_cycles), 32'd0);

        // flush and ext_stall together: flush wins
        load(5'd4);
        tick();
        nop();
        flush = 1'b1; ext_stall = 1'b1;
        #1;
        tick();
        flush = 1'b0; ext_stall = 1'b0;
        #1;
        chk("t5x_pend", 32'(if2.pending_cnt), 32'd0);

        // CNT_W=4: 20 load-use stalls saturate at 15
        sel = 4;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            load(5'd9);
            tick();
            use0(5'd9);
            tick();
            if (i == 13) chk("t6_cycles14", 32'(if4.stall_cycles), 32'd14);
        end
        chk("t6_saturate", 32'(if4.stall_cycles), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/load_hazard_scoreboard.md
# load_hazard_scoreboard

Parametrised load-use hazard detector for the OpenMIPS pipeline. It replaces the fixed single-cycle load-stall check in the control path. It tracks loads in flight for a configurable number of cycles after EX, compares them against every source operand of the instruction in ID, and raises a stall that holds IF/ID and injects a bubble into EX. It also keeps a saturating count of hazard-stall cycles for performance analysis.

## Interface
- REG_AW, 5, register address width
- NUM_SRC, 2, number of source operands checked per ID instruction
- LOAD_LAT, 1, cycles after entering EX during which load data is not forwardable (1 = classic 5-stage); must be ≥1
- CNT_W, 32, width of stall-cycle counter

- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- id_valid  in  1  ID holds a real instruction
- id_src_addr  in  NUM_SRC*REG_AW  source register addresses; source i at bits [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  source i is actually read
- id_is_load  in  1  ID instruction is a load
- id_dest_we  in  1  ID instruction writes a register
- id_dest_addr  in  REG_AW  ID destination register
- ext_stall  in  1  stall from another unit; freezes tracker state
- flush  in  1  pipeline flush (exception/branch); clears tracker
- stall_id  out  1  hazard stall request to ctrl
- hazard_src  out  NUM_SRC  per-source hazard match
- pending_cnt  out  $clog2(LOAD_LAT+1)  number of valid tracker entries
- stall_cycles  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Tracker: LOAD_LAT entries {valid, addr}. Entry 0 = load in EX; entry k = load k cycles past EX.
- Hazard: hazard_src[i] = id_valid & id_src_used[i] & (src_i != 0) & ∃k: entry[k].valid & entry[k].addr == src_i.
- stall_id = |hazard_src.
- Register 0 never matches and is never entered as valid.
- Update per rising edge, in priority order:
  - rst: all entries invalid; counter 0.
  - flush: all entries invalid. Counter unchanged.
  - ext_stall: tracker holds.
  - stall_id=1: tracker shifts (entry k → k+1; last entry drops); entry 0 gets a bubble (valid=0).
  - Otherwise: tracker shifts; entry 0 ← {id_valid & id_is_load & id_dest_we & (id_dest_addr≠0), id_dest_addr}.
- Counter: increments when stall_id & !ext_stall & !flush & !rst. Holds at 2^CNT_W−1; does not wrap.
- pending_cnt = popcount of entry valids.
- Multiple sources matching the same or different entries: each hazard_src bit is set independently; stall_id is a single bit.

## Timing
- stall_id and hazard_src are combinational from current ID inputs and registered tracker state, with zero-cycle latency. No path from stall_id back into its own inputs inside the block.
- Dependent instruction immediately behind a load: exactly LOAD_LAT stall cycles when ext_stall is low. Each ext_stall cycle extends the stall by one.
- Dependent at distance d (1 ≤ d ≤ LOAD_LAT): LOAD_LAT−d+1 stall cycles. Distance > LOAD_LAT: none.
- Reset values: entries invalid, stall_id=0, hazard_src=0, pending_cnt=0, stall_cycles=0.
- Reset or flush mid-stall: stall_id drops in the cycle after the edge, unless ID inputs re-match.
- Simultaneous flush and ext_stall: flush wins.

## Test plan
- Defaults, `lw $1,0($0)` then `ori $3,$1,1` → stall_id=1 for exactly 1 cycle, hazard_src=2'b01, stall_cycles=1; $3 gets the correct load value.
- LOAD_LAT=3, load to $5 followed by a consumer of $5 at distances 1, 2, 3, 4 → 3, 2, 1, 0 stall cycles respectively.
- Load to $0 followed by a consumer of $0; and a load with id_dest_we=0 → stall_id never asserts, pending_cnt stays 0.
- Load $7, then consumer with both sources $7 → hazard_src=2'b11, stall of 1 cycle. Same consumer with ext_stall high for 2 cycles during the stall → stall_id high for 3 cycles, stall_cycles increments only once.
- LOAD_LAT=2, load $4 then flush asserted one cycle → pending_cnt=0 on the next cycle and a $4 consumer does not stall. Repeat with rst instead of flush → same result, stall_cycles=0.
- CNT_W=4, force 20 back-to-back load-use stalls → stall_cycles saturates at 15.
